trap_ctrl: RTL

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_if.sv | 33 +++
 rtl/trap_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/trap_ctrl_if.sv
// trap_ctrl_if: signal bundle between the pipeline (master) and the trap controller (slave).
// Ports: inst_i/inst_addr_i/inst_valid_i mem-stage instruction, irq_i/irq_mask_i interrupt
// requests and enables, mstatus_i/mtvec_i/mepc_i CSR values; csr_we_o/csr_waddr_o/csr_wdata_o
// CSR write port, stallreq_o pipeline freeze, flush_o/new_pc_o redirect, irq_ack_o acknowledge.
interface trap_ctrl_if #(
    parameter int NUM_IRQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] inst_i;
    logic [ADDR_WIDTH-1:0] inst_addr_i;
    logic                  inst_valid_i;
    logic [NUM_IRQ-1:0]    irq_i;
    logic [NUM_IRQ-1:0]    irq_mask_i;
    logic [DATA_WIDTH-1:0] mstatus_i;
    logic [DATA_WIDTH-1:0] mtvec_i;
    logic [DATA_WIDTH-1:0] mepc_i;
    logic                  csr_we_o;
    logic [11:0]           csr_waddr_o;
    logic [DATA_WIDTH-1:0] csr_wdata_o;
    logic                  stallreq_o;
    logic                  flush_o;
    logic [ADDR_WIDTH-1:0] new_pc_o;
    logic [NUM_IRQ-1:0]    irq_ack_o;
    modport slave (
        input  inst_i, inst_addr_i, inst_valid_i, irq_i, irq_mask_i, mstatus_i, mtvec_i, mepc_i,
        output csr_we_o, csr_waddr_o, csr_wdata_o, stallreq_o, flush_o, new_pc_o, irq_ack_o
    );
    modport master (
        output inst_i, inst_addr_i, inst_valid_i, irq_i, irq_mask_i, mstatus_i, mtvec_i, mepc_i,
        input  csr_we_o, csr_waddr_o, csr_wdata_o, stallreq_o, flush_o, new_pc_o, irq_ack_o
    );
endinterface

// File: rtl/trap_ctrl.sv
// trap_ctrl: ecall/mret/interrupt sequencer writing mepc, mcause, mstatus then flushing to the handler.
// Ports: clk_i clock, rst_i async active-low reset, bus (trap_ctrl_if.slave) carrying all
// mem-stage, interrupt, CSR and redirect signals.
// Option: define TRAP_CTRL_VECTORED_EN for vectored interrupt targets when mtvec_i[1:0]==01.
module trap_ctrl #(
    parameter int NUM_IRQ    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic       clk_i,
    input  logic       rst_i,
    trap_ctrl_if.slave bus
);
    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    typedef enum logic [2:0] {IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS, FLUSH} state_t;
    typedef enum logic [1:0] {K_ECALL, K_MRET, K_IRQ} kind_t;
    state_t                state_q, state_d;
    kind_t                 kind_q, kind_d;
    logic [IW-1:0]         ch_q, ch_d, pend_ch;
    logic [ADDR_WIDTH-1:0] epc_q, epc_d, base, target;
    logic [NUM_IRQ-1:0]    sync1_q, sync2_q, pend;
    logic [DATA_WIDTH-1:0] mstatus_new, mcause;
    logic                  is_ecall, is_mret;
    logic                  unused_bits;
    assign pend        = sync2_q & bus.irq_mask_i & {NUM_IRQ{bus.mstatus_i[3]}};
    assign is_ecall    = bus.inst_i == DATA_WIDTH'(32'h0000_0073);
    assign is_mret     = bus.inst_i == DATA_WIDTH'(32'h3020_0073);
    assign base        = {bus.mtvec_i[ADDR_WIDTH-1:2], 2'b00};
    assign unused_bits = ^bus.mtvec_i[1:0];
    assign mcause      = (kind_q == K_IRQ) ? {1'b1, (DATA_WIDTH-1)'(32'(ch_q) + 32'd16)} : DATA_WIDTH'(11);
`ifdef TRAP_CTRL_VECTORED_EN
    assign target = (kind_q == K_MRET) ? bus.mepc_i[ADDR_WIDTH-1:0] :
                    (kind_q == K_IRQ && bus.mtvec_i[1:0] == 2'b01) ?
                    base + ADDR_WIDTH'((32'(ch_q) + 32'd16) << 2) : base;
`else
    assign target = (kind_q == K_MRET) ? bus.mepc_i[ADDR_WIDTH-1:0] : base;
`endif
    // lowest pending index wins: scan downward so the last hit is the smallest
    always_comb begin
        pend_ch = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (pend[i]) pend_ch = IW'(i);
    end
    // trap entry stacks MIE into MPIE and clears MIE; mret restores MIE and sets MPIE
    always_comb begin
        mstatus_new    = bus.mstatus_i;
        mstatus_new[7] = (kind_q == K_MRET) ? 1'b1 : bus.mstatus_i[3];
        mstatus_new[3] = (kind_q == K_MRET) ? bus.mstatus_i[7] : 1'b0;
    end
    always_comb begin
        state_d         = state_q;
        kind_d          = kind_q;
        ch_d            = ch_q;
        epc_d           = epc_q;
        bus.csr_we_o    = 1'b0;
        bus.csr_waddr_o = '0;
        bus.csr_wdata_o = '0;
        bus.flush_o     = 1'b0;
        bus.new_pc_o    = '0;
        bus.irq_ack_o   = '0;
        case (state_q)
            IDLE: if (bus.inst_valid_i && (is_ecall || is_mret || |pend)) begin
                kind_d  = is_ecall ? K_ECALL : is_mret ? K_MRET : K_IRQ;
                state_d = (is_mret && !is_ecall) ? WR_MSTATUS : WR_MEPC;
                ch_d    = pend_ch;
                epc_d   = bus.inst_addr_i;
            end
            WR_MEPC: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_waddr_o = 12'h341;
                bus.csr_wdata_o = DATA_WIDTH'(epc_q);
                state_d         = WR_MCAUSE;
            end
            WR_MCAUSE: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_waddr_o = 12'h342;
                bus.csr_wdata_o = mcause;
                state_d         = WR_MSTATUS;
            end
            WR_MSTATUS: begin
                bus.csr_we_o    = 1'b1;
                bus.csr_waddr_o = 12'h300;
                bus.csr_wdata_o = mstatus_new;
                state_d         = FLUSH;
            end
            FLUSH: begin
                bus.flush_o   = 1'b1;
                bus.new_pc_o  = target;
                bus.irq_ack_o = (kind_q == K_IRQ) ? NUM_IRQ'(1) << ch_q : '0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // gated by rst_i so the take-cycle stall cannot leak out while reset is held
    assign bus.stallreq_o = rst_i && ((state_q == IDLE) ? (state_d != IDLE) : (state_q != FLUSH));
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            kind_q  <= K_ECALL;
            ch_q    <= '0;
            epc_q   <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            ch_q    <= ch_d;
            epc_q   <= epc_d;
            sync1_q <= bus.irq_i;
            sync2_q <= sync1_q;
        end
    end
endmodule
